// File: rtl/fp_pkg.sv
// Shared constants and types for the pipelined floating-point add/subtract unit.
package fp_pkg;

  localparam int FP_EXP_WIDTH = 8;
  localparam int FP_SIG_WIDTH = 23;

  localparam int FP_FLAG_WIDTH    = 3;
  localparam int FP_FLAG_INVALID  = 2;
  localparam int FP_FLAG_OVERFLOW = 1;
  localparam int FP_FLAG_INEXACT  = 0;

  // Special-case outcome decided up front and carried down the pipe
  typedef enum logic [1:0] {
    SPC_NONE,
    SPC_NAN,
    SPC_INF
  } spc_e;

  // All-ones exponent pattern shared by infinity and NaN encodings
  function automatic logic [31:0] fp_exp_ones(input int ew);
    return (32'd1 << ew) - 32'd1;
  endfunction

  // Canonical quiet NaN: sign 0, exponent all ones, fraction MSB set
  function automatic logic [63:0] fp_qnan(input int ew, input int fw);
    return ((64'd1 << (ew + 1)) - 64'd1) << (fw - 1);
  endfunction

endpackage

// File: rtl/fp_lzc.sv
// Leading-zero counter; an all-zero input reports WIDTH.
module fp_lzc #(
  parameter int  WIDTH     = 27,
  localparam int CNT_WIDTH = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0]     data,
  output logic [CNT_WIDTH-1:0] count
);

  // Scan upward so the most significant set bit has the final say
  always_comb begin
    count = CNT_WIDTH'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (data[i]) begin
        count = CNT_WIDTH'(WIDTH - 1 - i);
      end
    end
  end

endmodule

// File: rtl/fp_addsub_pipe.sv
// Three-stage IEEE-754 add/subtract: align, add, normalise/round/pack.
module fp_addsub_pipe
  import fp_pkg::*;
#(
  parameter int  EXP_WIDTH          = FP_EXP_WIDTH,
  parameter int  SIGNIFICANDS_WIDTH = FP_SIG_WIDTH,
  localparam int DATA_WIDTH         = 1 + EXP_WIDTH + SIGNIFICANDS_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_WIDTH-1:0]    input_01,
  input  logic [DATA_WIDTH-1:0]    input_02,
  input  logic                     op,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    result,
  output logic [FP_FLAG_WIDTH-1:0] flags
);

  localparam int EW  = EXP_WIDTH;
  localparam int FW  = SIGNIFICANDS_WIDTH;
  localparam int MW  = EW + FW;
  localparam int AW  = FW + 4;
  localparam int SW  = FW + 5;
  localparam int XW  = EW + 2;
  localparam int LZW = $clog2(AW + 1);

  localparam logic [EW-1:0]         EXP_ONES    = EW'(fp_exp_ones(EW));
  localparam logic [DATA_WIDTH-1:0] QNAN        = DATA_WIDTH'(fp_qnan(EW, FW));
  localparam logic [EW-1:0]         SHIFT_LIMIT = EW'(FW + 3);

  logic en;
  logic v1, v2;

  assign en       = ~out_valid | out_ready;
  assign in_ready = en;

  // ---------------- S1: unpack, compare, swap, align ----------------
  logic          sign_a, sign_b;
  logic [EW-1:0] exp_a, exp_b;
  logic [FW-1:0] frac_a, frac_b;
  logic          nan_a, nan_b, snan_a, snan_b, inf_a, inf_b;
  logic [MW-1:0] mag_a, mag_b;

  assign sign_a = input_01[DATA_WIDTH-1];
  assign sign_b = input_02[DATA_WIDTH-1] ^ op;
  assign exp_a  = input_01[MW-1:FW];
  assign exp_b  = input_02[MW-1:FW];
  assign frac_a = input_01[FW-1:0];
  assign frac_b = input_02[FW-1:0];
  assign nan_a  = (exp_a == EXP_ONES) && (frac_a != '0);
  assign nan_b  = (exp_b == EXP_ONES) && (frac_b != '0);
  assign snan_a = nan_a && !frac_a[FW-1];
  assign snan_b = nan_b && !frac_b[FW-1];
  assign inf_a  = (exp_a == EXP_ONES) && (frac_a == '0);
  assign inf_b  = (exp_b == EXP_ONES) && (frac_b == '0);
  assign mag_a  = (exp_a == '0) ? '0 : input_01[MW-1:0];
  assign mag_b  = (exp_b == '0) ? '0 : input_02[MW-1:0];

  logic          big_sign;
  logic [MW-1:0] big_mag, small_mag;
  logic [EW-1:0] big_exp, small_exp, exp_diff;
  logic [FW:0]   big_man, small_man;
  logic [AW-1:0] small_full, shifted, lost, big_al, small_al;
  spc_e          spc_d;
  logic          spc_sign_d, invalid_d;

  // Order by magnitude, align the smaller operand and classify specials
  always_comb begin
    big_sign  = sign_a;
    big_mag   = mag_a;
    small_mag = mag_b;
    if (mag_b > mag_a) begin
      big_sign  = sign_b;
      big_mag   = mag_b;
      small_mag = mag_a;
    end
    big_exp    = big_mag[MW-1:FW];
    small_exp  = small_mag[MW-1:FW];
    big_man    = {big_exp != '0, big_mag[FW-1:0]};
    small_man  = {small_exp != '0, small_mag[FW-1:0]};
    exp_diff   = big_exp - small_exp;
    big_al     = {big_man, 3'b000};
    small_full = {small_man, 3'b000};
    shifted    = small_full >> exp_diff;
    lost       = small_full & ~({AW{1'b1}} << exp_diff);
    if (exp_diff >= SHIFT_LIMIT) begin
      small_al = {{(AW-1){1'b0}}, |small_man};
    end else begin
      small_al = {shifted[AW-1:1], shifted[0] | (|lost)};
    end

    spc_d      = SPC_NONE;
    spc_sign_d = 1'b0;
    invalid_d  = 1'b0;
    if (nan_a || nan_b) begin
      spc_d     = SPC_NAN;
      invalid_d = snan_a | snan_b;
    end else if (inf_a && inf_b && (sign_a != sign_b)) begin
      spc_d     = SPC_NAN;
      invalid_d = 1'b1;
    end else if (inf_a) begin
      spc_d      = SPC_INF;
      spc_sign_d = sign_a;
    end else if (inf_b) begin
      spc_d      = SPC_INF;
      spc_sign_d = sign_b;
    end
  end

  logic          s1_sign, s1_sub, s1_spc_sign, s1_invalid, s1_zero_sign;
  logic [EW-1:0] s1_exp;
  logic [AW-1:0] s1_big, s1_small;
  spc_e          s1_spc;

  // S1 register: aligned operands and special-case decision
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1           <= 1'b0;
      s1_sign      <= 1'b0;
      s1_sub       <= 1'b0;
      s1_spc_sign  <= 1'b0;
      s1_invalid   <= 1'b0;
      s1_zero_sign <= 1'b0;
      s1_exp       <= '0;
      s1_big       <= '0;
      s1_small     <= '0;
      s1_spc       <= SPC_NONE;
    end else if (en) begin
      v1           <= in_valid & in_ready;
      s1_sign      <= big_sign;
      s1_sub       <= sign_a ^ sign_b;
      s1_spc_sign  <= spc_sign_d;
      s1_invalid   <= invalid_d;
      s1_zero_sign <= sign_a & sign_b;
      s1_exp       <= big_exp;
      s1_big       <= big_al;
      s1_small     <= small_al;
      s1_spc       <= spc_d;
    end
  end

  // ---------------- S2: significand add/subtract ----------------
  logic [SW-1:0] sum_d;
  assign sum_d = s1_sub ? ({1'b0, s1_big} - {1'b0, s1_small})
                        : ({1'b0, s1_big} + {1'b0, s1_small});

  logic          s2_sign, s2_spc_sign, s2_invalid, s2_zero_sign;
  logic [EW-1:0] s2_exp;
  logic [SW-1:0] s2_sum;
  spc_e          s2_spc;

  // S2 register: raw sum with carry plus the context needed to pack it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2           <= 1'b0;
      s2_sign      <= 1'b0;
      s2_spc_sign  <= 1'b0;
      s2_invalid   <= 1'b0;
      s2_zero_sign <= 1'b0;
      s2_exp       <= '0;
      s2_sum       <= '0;
      s2_spc       <= SPC_NONE;
    end else if (en) begin
      v2           <= v1;
      s2_sign      <= s1_sign;
      s2_spc_sign  <= s1_spc_sign;
      s2_invalid   <= s1_invalid;
      s2_zero_sign <= s1_zero_sign;
      s2_exp       <= s1_exp;
      s2_sum       <= sum_d;
      s2_spc       <= s1_spc;
    end
  end

  // ---------------- S3: normalise, round, pack ----------------
  logic [LZW-1:0] lz;

  fp_lzc #(.WIDTH(AW)) u_lzc (
    .data  (s2_sum[AW-1:0]),
    .count (lz)
  );

  logic [AW-1:0]            norm;
  logic [XW-1:0]            exp_adj, exp_fin;
  logic [FW+1:0]            rounded;
  logic [FW-1:0]            frac_fin;
  logic                     underflow, round_up, inexact_r;
  logic [DATA_WIDTH-1:0]    res_d;
  logic [FP_FLAG_WIDTH-1:0] flags_d;

  // Normalise, round to nearest even and resolve special/exception results
  always_comb begin
    if (s2_sum[SW-1]) begin
      norm      = {s2_sum[SW-1:2], |s2_sum[1:0]};
      exp_adj   = {2'b00, s2_exp} + XW'(1);
      underflow = 1'b0;
    end else begin
      norm      = s2_sum[AW-1:0] << lz;
      exp_adj   = {2'b00, s2_exp} - XW'(lz);
      underflow = ({2'b00, s2_exp} <= XW'(lz));
    end
    round_up  = norm[2] & (norm[1] | norm[0] | norm[3]);
    inexact_r = |norm[2:0];
    rounded   = {1'b0, norm[AW-1:3]} + {{(FW+1){1'b0}}, round_up};
    if (rounded[FW+1]) begin
      frac_fin = rounded[FW:1];
      exp_fin  = exp_adj + XW'(1);
    end else begin
      frac_fin = rounded[FW-1:0];
      exp_fin  = exp_adj;
    end

    res_d   = '0;
    flags_d = '0;
    if (s2_spc == SPC_NAN) begin
      res_d                    = QNAN;
      flags_d[FP_FLAG_INVALID] = s2_invalid;
    end else if (s2_spc == SPC_INF) begin
      res_d = {s2_spc_sign, EXP_ONES, {FW{1'b0}}};
    end else if (s2_sum == '0) begin
      res_d = {s2_zero_sign, {MW{1'b0}}};
    end else if (underflow) begin
      res_d                    = {s2_sign, {MW{1'b0}}};
      flags_d[FP_FLAG_INEXACT] = 1'b1;
    end else if (exp_fin >= {2'b00, EXP_ONES}) begin
      res_d                     = {s2_sign, EXP_ONES, {FW{1'b0}}};
      flags_d[FP_FLAG_OVERFLOW] = 1'b1;
      flags_d[FP_FLAG_INEXACT]  = 1'b1;
    end else begin
      res_d                    = {s2_sign, exp_fin[EW-1:0], frac_fin};
      flags_d[FP_FLAG_INEXACT] = inexact_r;
    end
  end

  // S3 register: presented result, held while the consumer stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      flags     <= '0;
    end else if (en) begin
      out_valid <= v2;
      result    <= res_d;
      flags     <= flags_d;
    end
  end

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Self-checking bench for fp_addsub_pipe: vector table, back-pressure and reset sequences.
module tb_fp_addsub_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] input_01;
  logic [31:0] input_02;
  logic        op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [2:0]  flags;

  fp_addsub_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .input_01  (input_01),
    .input_02  (input_02),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
    logic [31:0] res;
    logic [2:0]  flg;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic [2:0]  flg;
    int          id;
  } exp_t;

  localparam int NVEC = 22;

  vec_t vecs[NVEC];
  exp_t sb_q[$];
  exp_t cur_exp;
  int   total    = 0;
  int   bad      = 0;
  int   out_seen = 0;
  int   accepted;
  int   seen_before;

  function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b, input logic o,
                              input logic [31:0] r, input logic [2:0] f);
    vec_t v;
    v.a = a; v.b = b; v.op = o; v.res = r; v.flg = f;
    return v;
  endfunction

  task automatic expectEq(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    expectEq($sformatf("vec%0d_result", e.id), result, e.res);
    expectEq($sformatf("vec%0d_flags", e.id), {29'b0, flags}, {29'b0, e.flg});
  endtask

  // Present one operation and hold it until the DUT takes it (bounded)
  task automatic applyStimulus(input vec_t v, input int id);
    int waited = 0;
    in_valid    = 1'b1;
    input_01    = v.a;
    input_02    = v.b;
    op          = v.op;
    cur_exp.res = v.res;
    cur_exp.flg = v.flg;
    cur_exp.id  = id;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("[TB] FAIL accept_timeout vec%0d: in_ready=%b expected 1", id, in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic waitDrain(input string name, input int bound);
    int n = 0;
    while (sb_q.size() != 0 && n < bound) begin
      @(posedge clk);
      n++;
    end
    expectEq(name, sb_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // Record the expected result for every accepted operation
  always @(negedge clk) begin
    if (!rst && in_valid && in_ready) begin
      sb_q.push_back(cur_exp);
    end
  end

  // Compare every delivered result against the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      out_seen++;
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_output: got result %h with no pending operation", result);
      end else begin
        e = sb_q.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0]  = mk(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 3'b000);
    vecs[1]  = mk(32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 3'b000);
    vecs[2]  = mk(32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 3'b100);
    vecs[3]  = mk(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b011);
    vecs[4]  = mk(32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 3'b001);
    vecs[5]  = mk(32'h3F800000, 32'h33800001, 1'b0, 32'h3F800001, 3'b001);
    vecs[6]  = mk(32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 3'b001);
    vecs[7]  = mk(32'h40400000, 32'hBF800000, 1'b0, 32'h40000000, 3'b000);
    vecs[8]  = mk(32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 3'b000);
    vecs[9]  = mk(32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 3'b000);
    vecs[10] = mk(32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 3'b000);
    vecs[11] = mk(32'h00000000, 32'h80000000, 1'b0, 32'h00000000, 3'b000);
    vecs[12] = mk(32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b000);
    vecs[13] = mk(32'h7F800001, 32'h00000000, 1'b0, 32'h7FC00000, 3'b100);
    vecs[14] = mk(32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 3'b000);
    vecs[15] = mk(32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 3'b000);
    vecs[16] = mk(32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 3'b000);
    vecs[17] = mk(32'h00C00000, 32'h00800000, 1'b1, 32'h00000000, 3'b001);
    vecs[18] = mk(32'h80C00000, 32'h80800000, 1'b1, 32'h80000000, 3'b001);
    vecs[19] = mk(32'h3F800000, 32'h3FC00000, 1'b0, 32'h40200000, 3'b000);
    vecs[20] = mk(32'h7F7FFFFF, 32'h73000000, 1'b0, 32'h7F800000, 3'b011);
    vecs[21] = mk(32'h3F800000, 32'h33800000, 1'b1, 32'h3F7FFFFF, 3'b000);

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    op        = 1'b0;
    input_01  = '0;
    input_02  = '0;
    cur_exp   = '{res: 32'h0, flg: 3'b000, id: -1};

    repeat (2) @(posedge clk);
    #1;
    expectEq("reset_out_valid", {31'b0, out_valid}, 32'd0);
    expectEq("reset_result", result, 32'd0);
    expectEq("reset_flags", {29'b0, flags}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    expectEq("reset_in_ready", {31'b0, in_ready}, 32'd1);

    $display("[TB] table vectors");
    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i], i);
    end
    waitDrain("table_drain", 20);

    $display("[TB] back-pressure sequence");
    out_ready   = 1'b0;
    accepted    = 0;
    seen_before = out_seen;
    for (int k = 0; k < 5; k++) begin
      in_valid    = 1'b1;
      input_01    = vecs[accepted + 4].a;
      input_02    = vecs[accepted + 4].b;
      op          = vecs[accepted + 4].op;
      cur_exp.res = vecs[accepted + 4].res;
      cur_exp.flg = vecs[accepted + 4].flg;
      cur_exp.id  = 100 + accepted;
      @(negedge clk);
      if (in_ready) accepted++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    expectEq("bp_accepted", accepted, 3);
    expectEq("bp_in_ready_low", {31'b0, in_ready}, 32'd0);
    expectEq("bp_out_valid_held", {31'b0, out_valid}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    expectEq("bp_still_stalled", {31'b0, in_ready}, 32'd0);
    out_ready = 1'b1;
    waitDrain("bp_drain", 20);
    repeat (3) @(posedge clk);
    #1;
    expectEq("bp_drain_count", out_seen - seen_before, 3);

    $display("[TB] reset with operations in flight");
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      input_01    = vecs[k].a;
      input_02    = vecs[k].b;
      op          = vecs[k].op;
      cur_exp.res = vecs[k].res;
      cur_exp.flg = vecs[k].flg;
      cur_exp.id  = 200 + k;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    rst      = 1'b1;
    #1;
    expectEq("rst_out_valid", {31'b0, out_valid}, 32'd0);
    expectEq("rst_result", result, 32'd0);
    expectEq("rst_flags", {29'b0, flags}, 32'd0);
    sb_q.delete();
    seen_before = out_seen;
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    expectEq("rst_no_stale", out_seen - seen_before, 0);
    expectEq("rst_in_ready", {31'b0, in_ready}, 32'd1);

    applyStimulus(vecs[19], 300);
    waitDrain("post_reset_drain", 20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fp_addsub_pipe.md
FP_ADDSUB_PIPE -- requirements
Module: fp_addsub_pipe

Interface
REQ-001 Parameter EXP_WIDTH, default 8, exponent field width.
REQ-002 Parameter SIGNIFICANDS_WIDTH, default 23, stored fraction width; DATA_WIDTH = 1+EXP_WIDTH+SIGNIFICANDS_WIDTH.
REQ-003 Port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  reset, asynchronous and active-high.
REQ-005 Port in_valid  input  1  operand pair and op presented.
REQ-006 Port in_ready  output  1  block accepts; transfer when in_valid & in_ready.
REQ-007 Port input_01, input_02  input  DATA_WIDTH  IEEE-754-format operands.
REQ-008 Port op  input  1  0 = input_01 + input_02, 1 = input_01 - input_02.
REQ-009 Port out_valid  output  1  result presented.
REQ-010 Port out_ready  input  1  consumer accepts; transfer when out_valid & out_ready.
REQ-011 Port result  output  DATA_WIDTH  packed sum/difference.
REQ-012 Port flags  output  3  {invalid, overflow, inexact} for the presented result.

Function
REQ-013 The pipeline SHALL have three stages: S1 unpack/compare/swap/align, S2 significand add/subtract, S3 normalise/round/pack; latency exactly 3 cycles with no stall.
REQ-014 Pipeline enable en SHALL be (~v3 | out_ready); in_ready SHALL equal en; all stages advance together when en=1 and hold when en=0.
REQ-015 Each stage valid bit SHALL load the previous valid (S1 loads in_valid & in_ready) when en=1; bubbles propagate as invalid.
REQ-016 Subtraction SHALL be effected by inverting sign of input_02 when op=1; effective operation = XOR of resulting signs.
REQ-017 S1 SHALL order operands by magnitude ({exp,frac} compare), set the result exponent to the larger one, and right-shift the smaller significand (with hidden 1) by the exponent difference, keeping guard, round and sticky bits; shift amounts >= SIGNIFICANDS_WIDTH+3 SHALL yield only sticky.
REQ-018 S2 SHALL add or subtract (larger minus smaller) in SIGNIFICANDS_WIDTH+5 bits including carry.
REQ-019 S3 SHALL normalise: carry-out shifts right by 1 and increments exponent; otherwise left-shift by leading-zero count, decrementing exponent.
REQ-020 Rounding SHALL be round-to-nearest-even; rounding carry-out SHALL renormalise and increment exponent.
REQ-021 Subnormal inputs SHALL be treated as signed zero; results below the minimum normal exponent SHALL flush to signed zero with inexact=1.
REQ-022 Exponent overflow (including after rounding) SHALL produce signed infinity with overflow=1 and inexact=1.
REQ-023 Any NaN input, or inf minus inf (effective), SHALL produce canonical quiet NaN (sign 0, exponent all-ones, fraction MSB 1, rest 0); invalid=1 only for signalling NaN input or inf minus inf.
REQ-024 Infinity with a finite operand SHALL pass the infinity with its effective sign, flags 0.
REQ-025 Exact zero result SHALL be +0, except (-0)+(-0) effective, which SHALL be -0.
REQ-026 inexact SHALL be 1 whenever any discarded bit (guard/round/sticky) was nonzero.
REQ-027 result and flags SHALL be stable while out_valid=1 and out_ready=0.

Reset
REQ-028 On rst=1 all stage valids SHALL clear immediately; out_valid=0, result=0, flags=0; in_ready=1 after reset releases.
REQ-029 Reset mid-operation SHALL discard all in-flight operations; no partial result SHALL appear afterwards.

Structure
REQ-030 Width parameters, special-encoding constants (qNaN, infinity exponent) and flag bit indices SHALL live in a shared package fp_pkg.
REQ-031 The leading-zero counter SHALL be a separate parametrised sub-module fp_lzc.

Verification
REQ-032 0x3F800000 + 0x3F800000, op=0 -> 0x40000000 three cycles later, flags=000.
REQ-033 0x3F800000 - 0x3F800000, op=1 -> 0x00000000, flags=000.
REQ-034 0x7F800000 - 0x7F800000, op=1 -> 0x7FC00000, flags=100.
REQ-035 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000, flags=011; 0x3F800000 + 0x33800000 -> 0x3F800000, flags=001 (tie to even).
REQ-036 Back-pressure: out_ready=0, five back-to-back valid inputs -> exactly three accepted, in_ready low thereafter; raising out_ready drains results in order with none lost or duplicated.
REQ-037 Assert rst with three operations in flight -> out_valid=0 immediately and no stale result after release.
